// File: rtl/pipe_stage_buf_pkg.sv
// Shared definitions for pipeline-stage buffers: stage payload widths, field
// offsets used to pack stage bundles, and width helpers for the buffer itself.
package pipe_stage_buf_pkg;

  // Stage payload widths.
  localparam int PL_F2D_W = 64;   // pc + instruction
  localparam int PL_D2X_W = 144;  // pc + rs1/rs2 values + imm + ctrl
  localparam int PL_X2M_W = 104;  // alu result + store data + rd + ctrl
  localparam int PL_M2W_W = 40;   // writeback value + rd + ctrl

  // IF->ID bundle field offsets.
  localparam int F2D_PC_LSB    = 0;
  localparam int F2D_INSTR_LSB = 32;

  typedef enum logic [1:0] {
    OCC_EMPTY,
    OCC_PARTIAL,
    OCC_FULL
  } occ_e;

  // A one-entry buffer still needs a 1-bit pointer to keep the ports legal.
  function automatic int ptr_width(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

  function automatic int cnt_width(input int depth);
    return (depth == 0) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_ptr_ctr.sv
// Modulo-DEPTH pointer with synchronous clear, used for the buffer read and
// write positions. Non-power-of-two depths wrap explicitly at DEPTH-1.
module pipe_ptr_ctr
  import pipe_stage_buf_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PW    = ptr_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_inc,
  output logic [PW-1:0] o_ptr
);

  logic [PW-1:0] r_ptr;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_ptr <= '0;
    end else if (i_inc) begin
      r_ptr <= (r_ptr == PW'(DEPTH - 1)) ? '0 : r_ptr + PW'(1);
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/pipe_stage_buf.sv
// Valid/ready pipeline-stage buffer: DEPTH=0 is a wire-through for single-cycle
// builds, DEPTH>=1 is a registered FIFO with flush for pipeline redirects.
module pipe_stage_buf
  import pipe_stage_buf_pkg::*;
#(
  parameter  int WIDTH      = 32,
  parameter  int DEPTH      = 2,
  parameter  bit READY_PASS = 1'b1,
  localparam int CW         = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [CW-1:0]    count
);

  if (DEPTH == 0) begin : g_pass

    assign s_ready = m_ready;
    assign m_valid = s_valid;
    assign m_data  = s_data;
    assign count   = '0;

    logic w_unused;
    assign w_unused = ^{clk, rst, flush};

  end else begin : g_fifo

    localparam int PW = ptr_width(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [CW-1:0]    r_count;
    logic [PW-1:0]    w_rd_ptr;
    logic [PW-1:0]    w_wr_ptr;
    occ_e             w_occ;
    logic             w_push;
    logic             w_pop;

    assign w_occ = (r_count == '0)         ? OCC_EMPTY :
                   (r_count == CW'(DEPTH)) ? OCC_FULL  : OCC_PARTIAL;

    // With READY_PASS a full buffer still accepts when the head leaves this cycle.
    assign s_ready = (w_occ != OCC_FULL) || (READY_PASS && m_ready);
    assign m_valid = (w_occ != OCC_EMPTY);
    assign m_data  = r_mem[w_rd_ptr];

    // A flush discards everything, including whatever is handshaken in that cycle.
    assign w_push = s_valid && s_ready && !flush;
    assign w_pop  = m_valid && m_ready && !flush;

    pipe_ptr_ctr #(.DEPTH(DEPTH)) u_wr_ptr (
      .clk   (clk),
      .rst   (rst),
      .i_clr (flush),
      .i_inc (w_push),
      .o_ptr (w_wr_ptr)
    );

    pipe_ptr_ctr #(.DEPTH(DEPTH)) u_rd_ptr (
      .clk   (clk),
      .rst   (rst),
      .i_clr (flush),
      .i_inc (w_pop),
      .o_ptr (w_rd_ptr)
    );

    always_ff @(posedge clk) begin
      if (rst || flush) begin
        r_count <= '0;
      end else begin
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CW'(1);
          2'b01:   r_count <= r_count - CW'(1);
          default: r_count <= r_count;
        endcase
      end
    end

    // NOTE: storage is cleared on reset so m_data reads 0 out of reset; flush
    // leaves it alone because m_valid already masks stale entries.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) begin
          r_mem[i] <= '0;
        end
      end else if (w_push) begin
        r_mem[w_wr_ptr] <= s_data;
      end
    end

    assign count = r_count;

  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench for pipe_stage_buf across depth 0/1/2/3 and both
// READY_PASS settings, driven from shared inputs with a queue-based model.
module tb_pipe_stage_buf;

  logic        clk      = 1'b0;
  logic        rst      = 1'b1;
  logic        flush    = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready = 1'b0;
  logic [31:0] in_data  = '0;

  logic        d1_s_ready, d1_m_valid;
  logic [31:0] d1_m_data;
  logic [0:0]  d1_count;

  logic        d3_s_ready [2];
  logic        d3_m_valid [2];
  logic [31:0] d3_m_data  [2];
  logic [1:0]  d3_count   [2];

  logic        d2_s_ready, d2_m_valid;
  logic [31:0] d2_m_data;
  logic [1:0]  d2_count;

  logic        d0_s_ready, d0_m_valid;
  logic [31:0] d0_m_data;
  logic [0:0]  d0_count;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] q1 [$];
  logic [31:0] q3 [2][$];

  always #5 clk = ~clk;

  pipe_stage_buf #(.WIDTH(32), .DEPTH(1), .READY_PASS(1'b1)) u_d1 (
    .clk(clk), .rst(rst), .flush(flush),
    .s_valid(in_valid), .s_ready(d1_s_ready), .s_data(in_data),
    .m_valid(d1_m_valid), .m_ready(in_ready), .m_data(d1_m_data), .count(d1_count)
  );

  pipe_stage_buf #(.WIDTH(32), .DEPTH(3), .READY_PASS(1'b0)) u_d3_rp0 (
    .clk(clk), .rst(rst), .flush(flush),
    .s_valid(in_valid), .s_ready(d3_s_ready[0]), .s_data(in_data),
    .m_valid(d3_m_valid[0]), .m_ready(in_ready), .m_data(d3_m_data[0]), .count(d3_count[0])
  );

  pipe_stage_buf #(.WIDTH(32), .DEPTH(3), .READY_PASS(1'b1)) u_d3_rp1 (
    .clk(clk), .rst(rst), .flush(flush),
    .s_valid(in_valid), .s_ready(d3_s_ready[1]), .s_data(in_data),
    .m_valid(d3_m_valid[1]), .m_ready(in_ready), .m_data(d3_m_data[1]), .count(d3_count[1])
  );

  pipe_stage_buf #(.WIDTH(32), .DEPTH(2), .READY_PASS(1'b1)) u_d2 (
    .clk(clk), .rst(rst), .flush(flush),
    .s_valid(in_valid), .s_ready(d2_s_ready), .s_data(in_data),
    .m_valid(d2_m_valid), .m_ready(in_ready), .m_data(d2_m_data), .count(d2_count)
  );

  pipe_stage_buf #(.WIDTH(32), .DEPTH(0), .READY_PASS(1'b1)) u_d0 (
    .clk(clk), .rst(rst), .flush(flush),
    .s_valid(in_valid), .s_ready(d0_s_ready), .s_data(in_data),
    .m_valid(d0_m_valid), .m_ready(in_ready), .m_data(d0_m_data), .count(d0_count)
  );

  // Reset for 3 cycles while upstream offers a payload that must be ignored.
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 32'hDEAD; in_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (d1_count !== 1'd0)    begin n_err++; $display("FAIL reset_d1_count: got %0d expected 0", d1_count); end
    n_cmp++; if (d1_m_valid !== 1'b0)  begin n_err++; $display("FAIL reset_d1_m_valid: got %b expected 0", d1_m_valid); end
    n_cmp++; if (d1_m_data !== 32'h0)  begin n_err++; $display("FAIL reset_d1_m_data: got %h expected 0", d1_m_data); end
    n_cmp++; if (d1_s_ready !== 1'b1)  begin n_err++; $display("FAIL reset_d1_s_ready: got %b expected 1", d1_s_ready); end
    for (int j = 0; j < 2; j++) begin
      n_cmp++; if (d3_count[j] !== 2'd0)   begin n_err++; $display("FAIL reset_d3_%0d_count: got %0d expected 0", j, d3_count[j]); end
      n_cmp++; if (d3_m_valid[j] !== 1'b0) begin n_err++; $display("FAIL reset_d3_%0d_m_valid: got %b expected 0", j, d3_m_valid[j]); end
      n_cmp++; if (d3_m_data[j] !== 32'h0) begin n_err++; $display("FAIL reset_d3_%0d_m_data: got %h expected 0", j, d3_m_data[j]); end
      n_cmp++; if (d3_s_ready[j] !== 1'b1) begin n_err++; $display("FAIL reset_d3_%0d_s_ready: got %b expected 1", j, d3_s_ready[j]); end
    end
    n_cmp++; if (d2_count !== 2'd0)    begin n_err++; $display("FAIL reset_d2_count: got %0d expected 0", d2_count); end
    n_cmp++; if (d2_m_valid !== 1'b0)  begin n_err++; $display("FAIL reset_d2_m_valid: got %b expected 0", d2_m_valid); end
    n_cmp++; if (d2_m_data !== 32'h0)  begin n_err++; $display("FAIL reset_d2_m_data: got %h expected 0", d2_m_data); end
  endtask

  // DEPTH=1 pipe register: one transfer per cycle, output lags input by one cycle.
  task automatic test_streaming();
    int pops = 0;
    do_reset();
    q1.delete();
    for (int i = 0; i <= 100; i++) begin
      @(posedge clk); #1;
      in_ready = 1'b1;
      in_valid = (i < 100);
      in_data  = i;
      #1;
      n_cmp++; if (d1_count !== 1'(q1.size())) begin n_err++; $display("FAIL stream_count[%0d]: got %0d expected %0d", i, d1_count, q1.size()); end
      n_cmp++; if (d1_s_ready !== 1'b1) begin n_err++; $display("FAIL stream_s_ready[%0d]: got %b expected 1", i, d1_s_ready); end
      n_cmp++; if (d1_m_valid !== (q1.size() != 0)) begin n_err++; $display("FAIL stream_m_valid[%0d]: got %b expected %b", i, d1_m_valid, q1.size() != 0); end
      if (q1.size() != 0) begin
        n_cmp++; if (d1_m_data !== q1[0]) begin n_err++; $display("FAIL stream_m_data[%0d]: got %h expected %h", i, d1_m_data, q1[0]); end
        void'(q1.pop_front());
        pops++;
      end
      if (in_valid) q1.push_back(in_data);
    end
    n_cmp++; if (pops != 100) begin n_err++; $display("FAIL stream_pop_total: got %0d expected 100", pops); end
  endtask

  // DEPTH=3 with the sink stalled: fill, refuse the fourth, then drain in order.
  task automatic test_backpressure();
    logic [31:0] vals [4];
    vals[0] = 32'hA000_000A; vals[1] = 32'hB000_000B;
    vals[2] = 32'hC000_000C; vals[3] = 32'hD000_000D;
    do_reset();
    in_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data  = vals[(k < 3) ? k : 3];
      #1;
      for (int j = 0; j < 2; j++) begin
        n_cmp++; if (d3_s_ready[j] !== (k < 3)) begin n_err++; $display("FAIL bp_s_ready_%0d[%0d]: got %b expected %b", j, k, d3_s_ready[j], k < 3); end
        n_cmp++; if (d3_count[j] !== 2'((k < 3) ? k : 3)) begin n_err++; $display("FAIL bp_count_%0d[%0d]: got %0d expected %0d", j, k, d3_count[j], (k < 3) ? k : 3); end
        if (k > 0) begin
          n_cmp++; if (d3_m_data[j] !== vals[0]) begin n_err++; $display("FAIL bp_head_stable_%0d[%0d]: got %h expected %h", j, k, d3_m_data[j], vals[0]); end
        end
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_ready = 1'b1;
    #1;
    n_cmp++; if (d3_s_ready[0] !== 1'b0) begin n_err++; $display("FAIL bp_full_ready_rp0: got %b expected 0", d3_s_ready[0]); end
    n_cmp++; if (d3_s_ready[1] !== 1'b1) begin n_err++; $display("FAIL bp_full_ready_rp1: got %b expected 1", d3_s_ready[1]); end
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 2; j++) begin
        n_cmp++; if (d3_m_valid[j] !== (k < 3)) begin n_err++; $display("FAIL bp_drain_valid_%0d[%0d]: got %b expected %b", j, k, d3_m_valid[j], k < 3); end
        if (k < 3) begin
          n_cmp++; if (d3_m_data[j] !== vals[k]) begin n_err++; $display("FAIL bp_drain_data_%0d[%0d]: got %h expected %h", j, k, d3_m_data[j], vals[k]); end
        end else begin
          n_cmp++; if (d3_count[j] !== 2'd0) begin n_err++; $display("FAIL bp_drain_count_%0d: got %0d expected 0", j, d3_count[j]); end
        end
      end
      @(posedge clk); #2;
    end
    in_ready = 1'b0;
  endtask

  // DEPTH=3, random traffic against a queue model for both READY_PASS settings.
  task automatic test_random();
    int full_push_pop = 0;
    do_reset();
    q3[0].delete();
    q3[1].delete();
    for (int i = 0; i < 10000; i++) begin
      @(posedge clk); #1;
      in_valid = ($urandom_range(0, 9) < 7);
      in_data  = $urandom;
      in_ready = ($urandom_range(0, 9) < (((i / 500) % 2 == 0) ? 4 : 8));
      #1;
      for (int j = 0; j < 2; j++) begin
        int  sz;
        bit  exp_sr, exp_mv, push, pop;
        sz     = q3[j].size();
        exp_mv = (sz != 0);
        exp_sr = (sz < 3) || ((j == 1) && in_ready);
        n_cmp++; if (d3_s_ready[j] !== exp_sr) begin n_err++; $display("FAIL rand_s_ready_%0d[%0d]: got %b expected %b", j, i, d3_s_ready[j], exp_sr); end
        n_cmp++; if (d3_m_valid[j] !== exp_mv) begin n_err++; $display("FAIL rand_m_valid_%0d[%0d]: got %b expected %b", j, i, d3_m_valid[j], exp_mv); end
        n_cmp++; if (d3_count[j] !== 2'(sz))   begin n_err++; $display("FAIL rand_count_%0d[%0d]: got %0d expected %0d", j, i, d3_count[j], sz); end
        if (exp_mv) begin
          n_cmp++; if (d3_m_data[j] !== q3[j][0]) begin n_err++; $display("FAIL rand_m_data_%0d[%0d]: got %h expected %h", j, i, d3_m_data[j], q3[j][0]); end
        end
        pop  = exp_mv && in_ready;
        push = in_valid && exp_sr;
        if ((sz == 3) && push && pop) full_push_pop++;
        if (pop)  void'(q3[j].pop_front());
        if (push) q3[j].push_back(in_data);
      end
    end
    n_cmp++; if (full_push_pop == 0) begin n_err++; $display("FAIL rand_full_push_pop_seen: got 0 expected >0"); end
    in_valid = 1'b0;
    in_ready = 1'b0;
  endtask

  // DEPTH=2 holding X,Y; flush with a live push of Z and a live pop of X.
  task automatic test_flush();
    do_reset();
    in_ready = 1'b0;
    @(posedge clk); #1; in_valid = 1'b1; in_data = 32'h0000_00A1; #1;
    @(posedge clk); #1; in_data = 32'h0000_00B2; #1;
    @(posedge clk); #1; in_data = 32'h0000_00C3; flush = 1'b1; in_ready = 1'b1; #1;
    n_cmp++; if (d2_count !== 2'd2)          begin n_err++; $display("FAIL flush_pre_count: got %0d expected 2", d2_count); end
    n_cmp++; if (d2_m_data !== 32'h0000_00A1) begin n_err++; $display("FAIL flush_pre_head: got %h expected 000000a1", d2_m_data); end
    n_cmp++; if (d2_s_ready !== 1'b1)        begin n_err++; $display("FAIL flush_pre_s_ready: got %b expected 1", d2_s_ready); end
    @(posedge clk); #1; flush = 1'b0; in_valid = 1'b0; #1;
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (d2_count !== 2'd0)   begin n_err++; $display("FAIL flush_post_count[%0d]: got %0d expected 0", k, d2_count); end
      n_cmp++; if (d2_m_valid !== 1'b0) begin n_err++; $display("FAIL flush_post_m_valid[%0d]: got %b expected 0 (data %h)", k, d2_m_valid, d2_m_data); end
      @(posedge clk); #2;
    end
    in_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h0000_00D4;
    @(posedge clk); #1; in_valid = 1'b0; #1;
    n_cmp++; if (d2_m_valid !== 1'b1)        begin n_err++; $display("FAIL flush_refill_valid: got %b expected 1", d2_m_valid); end
    n_cmp++; if (d2_m_data !== 32'h0000_00D4) begin n_err++; $display("FAIL flush_refill_data: got %h expected 000000d4", d2_m_data); end
  endtask

  // DEPTH=0: pure wires, same-cycle, flush has no effect.
  task automatic test_passthru();
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      in_valid = i[0];
      in_ready = i[1];
      flush    = i[2];
      in_data  = $urandom;
      #1;
      n_cmp++; if (d0_m_valid !== in_valid) begin n_err++; $display("FAIL pass_m_valid[%0d]: got %b expected %b", i, d0_m_valid, in_valid); end
      n_cmp++; if (d0_s_ready !== in_ready) begin n_err++; $display("FAIL pass_s_ready[%0d]: got %b expected %b", i, d0_s_ready, in_ready); end
      n_cmp++; if (d0_m_data !== in_data)   begin n_err++; $display("FAIL pass_m_data[%0d]: got %h expected %h", i, d0_m_data, in_data); end
      n_cmp++; if (d0_count !== 1'd0)       begin n_err++; $display("FAIL pass_count[%0d]: got %0d expected 0", i, d0_count); end
    end
    flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_random();
    test_flush();
    test_passthru();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
